// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared constants, pipeline payload types and helpers for the MIPS core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int          c_WORD_W    = 32;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
    localparam int          c_MAX_STALL = 2;

    typedef struct packed {
        logic [c_WORD_W-1:0] pc;
        logic [c_WORD_W-1:0] instr;
        logic                valid;
    } fd_t;

    typedef struct packed {
        logic [c_WORD_W-1:0] instr;
        logic                valid;
    } de_payload_t;

    function automatic logic [c_WORD_W-1:0] sat_inc(input logic [c_WORD_W-1:0] v);
        return (v == {c_WORD_W{1'b1}}) ? v : v + c_WORD_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_reg.sv
// ============================================================================
// Module  : pipe_reg
// Brief   : Generic pipeline register: clr loads CLR_VAL, en=0 holds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // clr wins over en so a reset or bubble always lands regardless of hold
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= CLR_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_front_regs.sv
// ============================================================================
// Module  : pipe_front_regs
// Brief   : PC, F/D and D/E registers with stall/bubble control and counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_front_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = mips_pkg::c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::c_NOP_INSTR,
    parameter int          MAX_STALL = mips_pkg::c_MAX_STALL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [c_WORD_W-1:0] F_npc,
    input  logic [c_WORD_W-1:0] F_instr,
    output logic [c_WORD_W-1:0] F_pc,
    output logic [c_WORD_W-1:0] D_pc,
    output logic [c_WORD_W-1:0] D_instr,
    output logic                D_valid,
    output logic [c_WORD_W-1:0] E_pc,
    output logic [c_WORD_W-1:0] E_instr,
    output logic                E_valid,
    output logic [c_WORD_W-1:0] bubble_cnt,
    output logic                stall_err
);

    localparam fd_t         c_FD_CLR  = '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    localparam de_payload_t c_DE_CLR  = '{instr: NOP_INSTR, valid: 1'b0};
    localparam int          c_RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [c_RUN_W-1:0] c_RUN_LIM = c_RUN_W'(MAX_STALL);
    localparam logic [c_RUN_W-1:0] c_RUN_SAT = c_RUN_W'(MAX_STALL + 1);

    fd_t         w_fd_d;
    fd_t         w_fd_q;
    de_payload_t w_de_d;
    de_payload_t w_de_q;

    logic [c_WORD_W-1:0] r_bubble_cnt;
    logic [c_RUN_W-1:0]  r_run_cnt;
    logic                r_stall_err;

    assign w_fd_d = '{pc: F_pc, instr: F_instr, valid: 1'b1};
    assign w_de_d = '{instr: w_fd_q.instr, valid: w_fd_q.valid};

    pipe_reg #(.W(c_WORD_W), .CLR_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .en  (~stall),
        .clr (reset),
        .d   (F_npc),
        .q   (F_pc)
    );

    pipe_reg #(.W($bits(fd_t)), .CLR_VAL(c_FD_CLR)) u_fd_reg (
        .clk (clk),
        .en  (~stall),
        .clr (reset),
        .d   (w_fd_d),
        .q   (w_fd_q)
    );

    // E_pc is split out so a bubble still carries the stalled instruction's PC
    pipe_reg #(.W(c_WORD_W), .CLR_VAL(RESET_PC)) u_de_pc_reg (
        .clk (clk),
        .en  (1'b1),
        .clr (reset),
        .d   (w_fd_q.pc),
        .q   (E_pc)
    );

    pipe_reg #(.W($bits(de_payload_t)), .CLR_VAL(c_DE_CLR)) u_de_reg (
        .clk (clk),
        .en  (1'b1),
        .clr (reset | stall),
        .d   (w_de_d),
        .q   (w_de_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_run_cnt    <= '0;
            r_stall_err  <= 1'b0;
        end else if (stall) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
            if (r_run_cnt != c_RUN_SAT) begin
                r_run_cnt <= r_run_cnt + c_RUN_W'(1);
            end
            if (r_run_cnt == c_RUN_LIM) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_run_cnt <= '0;
        end
    end

    assign D_pc       = w_fd_q.pc;
    assign D_instr    = w_fd_q.instr;
    assign D_valid    = w_fd_q.valid;
    assign E_instr    = w_de_q.instr;
    assign E_valid    = w_de_q.valid;
    assign bubble_cnt = r_bubble_cnt;
    assign stall_err  = r_stall_err;

endmodule

`default_nettype wire
